// File: rtl/exu_br_resolve_ctl_pkg.sv
// Shared branch-resolution types: the predictor packet coming from the ALU,
// the update record queued towards the IFU, and the redirect FSM encodings.
package veer_types;

  typedef struct packed {
    logic        misp;
    logic        ataken;
    logic        boffset;
    logic        pc4;
    logic [1:0]  hist;
    logic [11:0] toffset;
    logic        valid;
    logic        br_error;
    logic        br_start_error;
    logic        way;
  } predict_pkt_t;

  typedef struct packed {
    logic [31:1] pc;
    logic [1:0]  hist;
    logic        misp;
    logic        ataken;
  } br_upd_pkt_t;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_SHADOW = 1'b1;

  typedef enum logic {
    IDLE   = ST_IDLE,
    SHADOW = ST_SHADOW
  } br_state_e;

endpackage

// File: rtl/exu_br_resolve_ctl_upd_fifo.sv
// Synchronous valid/ready FIFO of predictor update records. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
// A push into a full FIFO without a same-cycle pop is discarded and flagged.
module exu_br_upd_fifo
  import veer_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        push,
  input  br_upd_pkt_t push_data,
  input  logic        pop_ready,
  output logic        head_valid,
  output br_upd_pkt_t head_data,
  output logic        drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  br_upd_pkt_t mem [DEPTH];
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = ~empty & pop_ready;
  assign wr_en      = push & (~full | pop);
  assign head_valid = ~empty;
  assign head_data  = mem[rd_ptr[AW-1:0]];

  // Pointer advance and drop pulse; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      drop <= push & full & ~pop;
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/exu_br_resolve_ctl.sv
// Branch resolution: arbitrates ALU (upper) and commit (lower) flushes into a
// single registered front-end redirect, suppresses younger upper flushes for a
// short shadow after each redirect, and queues predictor updates to the IFU.
// Optional performance counters are built when EXU_BR_PERF_EN is defined.
module exu_br_resolve_ctl
  import veer_types::*;
#(
  parameter int DEPTH      = 4,
  parameter int SHADOW_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             alu_valid_ff,
  input  logic             flush_upper,
  input  logic [31:1]      flush_path,
  input  logic [31:1]      pc_ff,
  input  predict_pkt_t     predict_p_ff,
  input  logic             flush_lower,
  input  logic [31:1]      flush_lower_path,
  output logic             exu_flush_final,
  output logic [31:1]      exu_flush_path_final,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [31:1]      upd_pc,
  output logic [1:0]       upd_hist,
  output logic             upd_misp,
  output logic             upd_taken,
  output logic             upd_drop,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_misp_cnt
);

  localparam int SH_W = $clog2(SHADOW_CYC + 1);

  br_state_e   state;
  br_state_e   state_nxt;
  logic [SH_W-1:0] sh_cnt;
  logic [SH_W-1:0] sh_cnt_nxt;
  logic        lower_fire;
  logic        upper_fire;
  logic        fire;
  logic        push;
  logic        flush_p1;
  logic [31:1] flush_path_p1;
  br_upd_pkt_t upd_pkt;
  br_upd_pkt_t head_pkt;
  logic        pkt_unused;

  // Lower (older) flush always wins; upper only when idle and not frozen.
  assign lower_fire = flush_lower;
  assign upper_fire = flush_upper & alu_valid_ff & ~freeze & (state == IDLE) & ~flush_lower;
  assign fire       = lower_fire | upper_fire;

  assign push = alu_valid_ff & predict_p_ff.valid & ~freeze & ~flush_lower
              & ((state == IDLE) | upper_fire);

  assign upd_pkt.pc     = pc_ff;
  assign upd_pkt.hist   = predict_p_ff.hist;
  assign upd_pkt.misp   = predict_p_ff.misp;
  assign upd_pkt.ataken = predict_p_ff.ataken;

  assign pkt_unused = ^{predict_p_ff.boffset, predict_p_ff.pc4, predict_p_ff.toffset,
                        predict_p_ff.br_error, predict_p_ff.br_start_error, predict_p_ff.way};

  // Redirect FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state  <= IDLE;
      sh_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sh_cnt <= sh_cnt_nxt;
    end
  end

  // Next state: any fire (re)opens the shadow; it drains on unfrozen cycles.
  always_comb begin
    state_nxt  = state;
    sh_cnt_nxt = sh_cnt;
    if (fire) begin
      state_nxt  = SHADOW;
      sh_cnt_nxt = SH_W'(SHADOW_CYC);
    end else if ((state == SHADOW) && !freeze) begin
      sh_cnt_nxt = sh_cnt - 1'b1;
      if (sh_cnt == SH_W'(1)) state_nxt = IDLE;
    end
  end

  // Stage p0 -> p1: registered redirect; path holds when nothing fires.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      flush_p1      <= 1'b0;
      flush_path_p1 <= '0;
    end else begin
      flush_p1 <= fire;
      if (fire) flush_path_p1 <= lower_fire ? flush_lower_path : flush_path;
    end
  end

  assign exu_flush_final      = flush_p1;
  assign exu_flush_path_final = flush_path_p1;

  exu_br_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_upd_fifo (
    .clk        (clk),
    .rst_l      (rst_l),
    .push       (push),
    .push_data  (upd_pkt),
    .pop_ready  (upd_ready),
    .head_valid (upd_valid),
    .head_data  (head_pkt),
    .drop       (upd_drop)
  );

  assign upd_pc    = head_pkt.pc;
  assign upd_hist  = head_pkt.hist;
  assign upd_misp  = head_pkt.misp;
  assign upd_taken = head_pkt.ataken;

`ifdef EXU_BR_PERF_EN
  logic [CNT_W-1:0] br_cnt_p1;
  logic [CNT_W-1:0] misp_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counts every branch offered for update, and the mispredicted subset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      br_cnt_p1   <= '0;
      misp_cnt_p1 <= '0;
    end else if (push) begin
      br_cnt_p1 <= sat_inc(br_cnt_p1);
      if (predict_p_ff.misp) misp_cnt_p1 <= sat_inc(misp_cnt_p1);
    end
  end

  assign perf_br_cnt   = br_cnt_p1;
  assign perf_misp_cnt = misp_cnt_p1;
`else
  assign perf_br_cnt   = '0;
  assign perf_misp_cnt = '0;
`endif

endmodule
